// File: rtl/div_pkg.sv
// Shared definitions for the divider strobe monitor.
//   state encoding : IDLE / ACQ / LOCK as plain 2-bit constants
//   timeout_of()   : saturation point of the interval counter
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ACQ  = 2'd1;
  localparam state_t ST_LOCK = 2'd2;

  localparam int CNT_W = 4;

  // Interval counter saturates at twice the expected period. The counter is
  // only 4 bits, so periods above 7 clamp the timeout at 15.
  function automatic logic [CNT_W-1:0] timeout_of(input int exp_period);
    int t;
    t = 2 * exp_period;
    if (t > 15) t = 15;
    return t[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/div_int_cnt.sv
// Interval counter between divider strobes.
//   clk, rst    : rising-edge clock, async active-high reset
//   pi_flag_i   : divider strobe
//   int_cnt_o   : 1 in the cycle after a strobe, counting up, saturating
//                 at the timeout value
module div_int_cnt
  import div_pkg::*;
#(
  parameter int EXP_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_flag_i,
  output logic [CNT_W-1:0] int_cnt_o
);

  localparam logic [CNT_W-1:0] TIMEOUT = timeout_of(EXP_PERIOD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pi_flag_i)
      cnt_d = 4'd1;
    else if (cnt_q != TIMEOUT)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign int_cnt_o = cnt_q;

endmodule

// File: rtl/div_mon.sv
// Divider strobe monitor: checks that pi_flag arrives every EXP_PERIOD
// cycles, locks after LOCK_CNT consecutive good intervals and reports early
// or missing strobes while locked.
//   clk, rst     : rising-edge clock, async active-high reset
//   pi_flag      : one-cycle strobe from the divider
//   locked       : high while the monitor is in LOCK
//   err_pulse    : one-cycle pulse per period error seen in LOCK
//   err_cnt      : saturating error count
//   period_meas  : last interval measured in ACQ or LOCK
//
// state | meaning
// IDLE  | no reference strobe yet (or lost it on timeout)
// ACQ   | counting consecutive good intervals
// LOCK  | period confirmed, watching for early / missing strobes
module div_mon
  import div_pkg::*;
#(
  parameter int EXP_PERIOD = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pi_flag,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       period_meas
);

  localparam logic [CNT_W-1:0] EXP_P   = 4'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] LOCK_C  = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT = timeout_of(EXP_PERIOD);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [CNT_W-1:0] int_cnt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] good_inc;
  logic             locked_q;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       pm_q, pm_d;
  logic             lock_err;

  div_int_cnt #(
    .EXP_PERIOD (EXP_PERIOD)
  ) u_int_cnt (
    .clk       (clk),
    .rst       (rst),
    .pi_flag_i (pi_flag),
    .int_cnt_o (int_cnt)
  );

  assign good_inc = good_q + 4'd1;

  // Early: strobe before the period elapsed. Missing: period reached with no
  // strobe. An early strobe still reloads int_cnt, so it becomes the new
  // reference for the following interval.
  assign lock_err = (pi_flag && (int_cnt < EXP_P)) ||
                    (!pi_flag && (int_cnt == EXP_P));

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    pm_d      = pm_q;

    case (state_q)
      ST_IDLE: begin
        // First strobe only sets the reference; nothing is measured.
        if (pi_flag) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
      end

      ST_ACQ: begin
        if (pi_flag) begin
          pm_d = int_cnt;
          if (int_cnt == EXP_P) begin
            good_d = good_inc;
            if (good_inc == LOCK_C) state_d = ST_LOCK;
          end else begin
            good_d = '0;
          end
        end else if (int_cnt == TIMEOUT) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCK: begin
        if (pi_flag) pm_d = int_cnt;
        if (lock_err) begin
          state_d = ST_ACQ;
          good_d  = '0;
          err_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase

    if (err_d && (err_cnt_q != ERR_MAX)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      good_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      pm_q      <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      // Registered from the next state so locked tracks state == LOCK.
      locked_q  <= (state_d == ST_LOCK);
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      pm_q      <= pm_d;
    end
  end

  assign locked      = locked_q;
  assign err_pulse   = err_q;
  assign err_cnt     = err_cnt_q;
  assign period_meas = pm_q;

endmodule

// File: tb/tb_div_mon.sv
module tb_div_mon;

  localparam int EXP = 4;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pi_flag = 1'b0;
  logic       locked, err_pulse;
  logic [7:0] err_cnt;
  logic [3:0] pm;
  logic       s_locked, s_err;
  logic [1:0] s_cnt;
  logic [3:0] s_pm;

  always #5 clk = ~clk;

  div_mon #(.EXP_PERIOD(4), .LOCK_CNT(3), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .pi_flag(pi_flag), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt), .period_meas(pm));

  div_mon #(.EXP_PERIOD(4), .LOCK_CNT(3), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .pi_flag(pi_flag), .locked(s_locked),
    .err_pulse(s_err), .err_cnt(s_cnt), .period_meas(s_pm));

  int total = 0;
  int bad   = 0;

  // reference model: cycles since last strobe (capped), acquisition mode,
  // run of good intervals, and the expected registered outputs
  int m_since, m_mode, m_good, m_pm, m_cnt8, m_cnt2;
  bit m_lock, m_err;

  int o_lock[128], o_err[128], o_serr[128], o_cnt[128], o_scnt[128], o_pm[128];
  logic [127:0] pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_since = 0; m_mode = 0; m_good = 0; m_pm = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_lock = 0; m_err = 0;
  endtask

  task automatic model_step(input bit f);
    int ival = m_since;
    int prev = m_mode;
    m_err = 0;
    if (m_mode == 0) begin
      if (f) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (f) begin
        if (ival == EXP) begin
          m_good++;
          if (m_good == 3) m_mode = 2;
        end else m_good = 0;
      end else if (ival == TO) m_mode = 0;
    end else begin
      if ((f && ival < EXP) || (!f && ival == EXP)) begin
        m_err = 1; m_mode = 1; m_good = 0;
      end
    end
    if (f && prev != 0) m_pm = ival;
    if (m_err) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_since = f ? 1 : ((m_since + 1 > TO) ? TO : m_since + 1);
    m_lock = (m_mode == 2);
  endtask

  // one cycle: compare outputs of the current cycle, record, then drive
  task automatic tick(input bit f, input int idx);
    @(negedge clk);
    chk("locked", locked, m_lock);
    chk("sat_locked", s_locked, m_lock);
    chk("err_pulse", err_pulse, m_err);
    chk("sat_err_pulse", s_err, m_err);
    chk("err_cnt", err_cnt, m_cnt8);
    chk("sat_err_cnt", s_cnt, m_cnt2);
    chk("period_meas", pm, m_pm);
    chk("sat_period_meas", s_pm, m_pm);
    if (idx >= 0 && idx < 128) begin
      o_lock[idx] = locked; o_err[idx] = err_pulse; o_serr[idx] = s_err;
      o_cnt[idx] = err_cnt; o_scnt[idx] = s_cnt; o_pm[idx] = pm;
    end
    pi_flag = f;
    model_step(f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pi_flag = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0);
  endtask

  task automatic play(input int n);
    for (int c = 0; c < n; c++) tick(pat[c], c);
  endtask

  task automatic lock_pattern();
    pat = '0;
    for (int i = 0; i <= 12; i += 4) pat[i] = 1'b1;
  endtask

  int nerr;
  int left, hold, r;
  bit f;

  initial begin
    model_reset();
    #2;
    chk("reset_locked", locked, 0);
    chk("reset_err_pulse", err_pulse, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_period_meas", pm, 0);

    // clean lock, then one early strobe and relock
    do_reset();
    lock_pattern();
    pat[16] = 1; pat[18] = 1; pat[22] = 1; pat[26] = 1; pat[30] = 1;
    play(34);
    chk("clean_not_locked_c12", o_lock[12], 0);
    chk("clean_locked_c13", o_lock[13], 1);
    chk("clean_err_cnt", o_cnt[13], 0);
    chk("clean_period", o_pm[17], 4);
    chk("early_no_pulse_c18", o_err[18], 0);
    chk("early_pulse_c19", o_err[19], 1);
    chk("early_pulse_gone_c20", o_err[20], 0);
    chk("early_err_cnt", o_cnt[19], 1);
    chk("early_unlocked", o_lock[19], 0);
    chk("early_period", o_pm[19], 2);
    chk("relock_c30", o_lock[30], 0);
    chk("relock_c31", o_lock[31], 1);

    // async reset between edges while locked
    @(posedge clk);
    #3;
    chk("pre_reset_locked", locked, 1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_locked", locked, 0);
    chk("async_err_cnt", err_cnt, 0);
    chk("async_period", pm, 0);
    chk("async_err_pulse", err_pulse, 0);
    chk("async_sat_cnt", s_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0);
    lock_pattern();
    play(16);
    chk("rst_relock_c12", o_lock[12], 0);
    chk("rst_relock_c13", o_lock[13], 1);

    // missing strobe, timeout to IDLE, reacquire
    do_reset();
    lock_pattern();
    pat[24] = 1; pat[28] = 1; pat[32] = 1; pat[36] = 1;
    play(40);
    chk("miss_locked_c16", o_lock[16], 1);
    chk("miss_no_pulse_c16", o_err[16], 0);
    chk("miss_pulse_c17", o_err[17], 1);
    chk("miss_unlocked_c17", o_lock[17], 0);
    chk("miss_err_cnt", o_cnt[17], 1);
    chk("miss_idle_no_measure", o_pm[25], 4);
    chk("miss_relock_c36", o_lock[36], 0);
    chk("miss_relock_c37", o_lock[37], 1);

    // pi_flag stuck high for 6 cycles while locked
    do_reset();
    lock_pattern();
    for (int i = 16; i <= 21; i++) pat[i] = 1'b1;
    pat[25] = 1; pat[29] = 1; pat[33] = 1;
    play(36);
    nerr = 0;
    for (int i = 0; i < 36; i++) nerr += o_err[i];
    chk("stuck_locked_c17", o_lock[17], 1);
    chk("stuck_pulse_c18", o_err[18], 1);
    chk("stuck_one_error", nerr, 1);
    chk("stuck_err_cnt", o_cnt[22], 1);
    chk("stuck_period", o_pm[22], 1);
    chk("stuck_in_acq", o_pm[26], 4);
    chk("stuck_relock_c34", o_lock[34], 1);

    // five errors into a 2-bit counter
    do_reset();
    lock_pattern();
    for (int k = 0; k < 5; k++) begin
      pat[14 + 14*k] = 1; pat[18 + 14*k] = 1;
      pat[22 + 14*k] = 1; pat[26 + 14*k] = 1;
    end
    play(86);
    nerr = 0;
    for (int i = 0; i < 86; i++) nerr += o_serr[i];
    chk("sat_pulses", nerr, 5);
    chk("sat_cnt_before_third", o_scnt[42], 2);
    chk("sat_cnt_third", o_scnt[43], 3);
    chk("sat_cnt_fourth", o_scnt[57], 3);
    chk("sat_cnt_final", o_scnt[85], 3);
    chk("wide_cnt_final", o_cnt[85], 5);
    chk("sat_relocked", o_lock[84], 1);

    // randomized strobe gaps, mostly nominal, with jitter and stuck-high bursts
    do_reset();
    left = 4; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      f = 1'b0;
      if (hold > 0) begin
        f = 1'b1; hold--;
      end else begin
        left--;
        if (left <= 0) begin
          f = 1'b1;
          r = int'($urandom_range(0, 19));
          left = (r < 14) ? 4 : int'($urandom_range(1, 11));
          if (r == 19) hold = int'($urandom_range(1, 5));
        end
      end
      tick(f, -1);
    end
    tick(1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
